// File: rtl/quad_corr_cascade_sum.sv
// rtl/quad_corr_cascade_sum.sv - aligned six-stage adder cascade with threshold flag and windowed peak
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   STAGE1A..STAGE4B         unregistered partition buses, set t at cycle t
//   STAGE5A..STAGE6B         registered pre-add buses, set t at cycle t+1
//   THRESHOLD                unsigned trigger threshold, sampled every clock
//   SUM_OUT / SUM_VALID      total of one aligned set, post-fill qualifier
//   OVER_THR                 SUM_VALID && SUM_OUT >= THRESHOLD, one clock later
//   MAX_OUT / MAX_IDX        peak and in-window position of the last full window
//   MAX_VALID                one-clock strobe when MAX_OUT/MAX_IDX update
module quad_corr_cascade_sum #(
  parameter int DSPBITS = 12,
  parameter int SUMBITS = 12,
  parameter int WINDOW  = 8,
  parameter int IDXBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DSPBITS-1:0] STAGE1A,
  input  logic [DSPBITS-1:0] STAGE1B,
  input  logic [DSPBITS-1:0] STAGE2A,
  input  logic [DSPBITS-1:0] STAGE2B,
  input  logic [DSPBITS-1:0] STAGE3A,
  input  logic [DSPBITS-1:0] STAGE3B,
  input  logic [DSPBITS-1:0] STAGE4A,
  input  logic [DSPBITS-1:0] STAGE4B,
  input  logic [DSPBITS-1:0] STAGE5A,
  input  logic [DSPBITS-1:0] STAGE5B,
  input  logic [DSPBITS-1:0] STAGE6A,
  input  logic [DSPBITS-1:0] STAGE6B,
  input  logic [SUMBITS-1:0] THRESHOLD,
  output logic [SUMBITS-1:0] SUM_OUT,
  output logic               SUM_VALID,
  output logic               OVER_THR,
  output logic [SUMBITS-1:0] MAX_OUT,
  output logic [IDXBITS-1:0] MAX_IDX,
  output logic               MAX_VALID
);

  localparam int WB   = (DSPBITS > SUMBITS) ? DSPBITS : SUMBITS;
  // Triangular delay store: stage s (0-based) owns s taps starting at s*(s-1)/2.
  localparam int NTAP = 15;
  localparam logic [IDXBITS-1:0] LAST = IDXBITS'(WINDOW - 1);

  typedef enum logic {FILL, RUN} state_t;

  function automatic logic [SUMBITS-1:0] fit(input logic [DSPBITS-1:0] x);
    logic [WB-1:0] w;
    w = WB'(x);
    return w[SUMBITS-1:0];
  endfunction

  logic [SUMBITS-1:0] al_a_q [4];
  logic [SUMBITS-1:0] al_a_d [4];
  logic [SUMBITS-1:0] al_b_q [4];
  logic [SUMBITS-1:0] al_b_d [4];
  logic [SUMBITS-1:0] src_a  [6];
  logic [SUMBITS-1:0] src_b  [6];
  logic [SUMBITS-1:0] tap_a  [6];
  logic [SUMBITS-1:0] tap_b  [6];
  logic [SUMBITS-1:0] dl_a_q [NTAP];
  logic [SUMBITS-1:0] dl_a_d [NTAP];
  logic [SUMBITS-1:0] dl_b_q [NTAP];
  logic [SUMBITS-1:0] dl_b_d [NTAP];
  logic [SUMBITS-1:0] p_q    [6];
  logic [SUMBITS-1:0] p_d    [6];
  logic [6:0]         vld_q, vld_d;
  state_t             state_q, state_d;
  logic [IDXBITS-1:0] cnt_q, cnt_d;
  logic [SUMBITS-1:0] run_max_q, run_max_d;
  logic [IDXBITS-1:0] run_idx_q, run_idx_d;
  logic [SUMBITS-1:0] max_out_q, max_out_d;
  logic [IDXBITS-1:0] max_idx_q, max_idx_d;
  logic               max_valid_q, max_valid_d;
  logic               over_thr_q, over_thr_d;
  logic               sum_valid;
  logic [SUMBITS-1:0] sum_q;
  logic               take;

  assign sum_valid = vld_q[6];
  assign sum_q     = p_q[5];

  // Stages 1-4 get one register so they line up with the already-registered 5-6.
  always_comb begin
    al_a_d[0] = fit(STAGE1A);  al_b_d[0] = fit(STAGE1B);
    al_a_d[1] = fit(STAGE2A);  al_b_d[1] = fit(STAGE2B);
    al_a_d[2] = fit(STAGE3A);  al_b_d[2] = fit(STAGE3B);
    al_a_d[3] = fit(STAGE4A);  al_b_d[3] = fit(STAGE4B);
    for (int s = 0; s < 4; s++) begin
      src_a[s] = al_a_q[s];
      src_b[s] = al_b_q[s];
    end
    src_a[4] = fit(STAGE5A);  src_b[4] = fit(STAGE5B);
    src_a[5] = fit(STAGE6A);  src_b[5] = fit(STAGE6B);
  end

  // Stage s waits s clocks so its operands meet the partial sum of the same set.
  always_comb begin
    dl_a_d   = dl_a_q;
    dl_b_d   = dl_b_q;
    tap_a[0] = src_a[0];
    tap_b[0] = src_b[0];
    for (int s = 1; s < 6; s++) begin
      dl_a_d[s*(s-1)/2] = src_a[s];
      dl_b_d[s*(s-1)/2] = src_b[s];
      for (int j = 1; j < 5; j++) begin
        if (j < s) begin
          dl_a_d[s*(s-1)/2 + j] = dl_a_q[s*(s-1)/2 + j - 1];
          dl_b_d[s*(s-1)/2 + j] = dl_b_q[s*(s-1)/2 + j - 1];
        end
      end
      tap_a[s] = dl_a_q[s*(s-1)/2 + s - 1];
      tap_b[s] = dl_b_q[s*(s-1)/2 + s - 1];
    end
  end

  always_comb begin
    p_d[0] = tap_a[0] + tap_b[0];
    for (int s = 1; s < 6; s++) begin
      p_d[s] = p_q[s-1] + tap_a[s] + tap_b[s];
    end
    vld_d = {vld_q[5:0], 1'b1};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_out_d   = max_out_q;
    max_idx_d   = max_idx_q;
    max_valid_d = 1'b0;
    over_thr_d  = sum_valid && (sum_q >= THRESHOLD);
    take        = 1'b0;
    case (state_q)
      FILL: begin
        // The first valid sample is also window position 0.
        if (sum_valid) begin
          state_d = RUN;
          take    = 1'b1;
        end
      end
      RUN:     take = sum_valid;
      default: state_d = FILL;
    endcase
    if (take) begin
      if (cnt_q == '0) begin
        run_max_d = sum_q;
        run_idx_d = '0;
      end else if (sum_q > run_max_q) begin
        run_max_d = sum_q;
        run_idx_d = cnt_q;
      end
      if (cnt_q == LAST) begin
        // Publish including this final sample, in the same edge.
        cnt_d       = '0;
        max_out_d   = run_max_d;
        max_idx_d   = run_idx_d;
        max_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      al_a_q      <= '{default: '0};
      al_b_q      <= '{default: '0};
      dl_a_q      <= '{default: '0};
      dl_b_q      <= '{default: '0};
      p_q         <= '{default: '0};
      vld_q       <= '0;
      state_q     <= FILL;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_out_q   <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
      over_thr_q  <= 1'b0;
    end else begin
      al_a_q      <= al_a_d;
      al_b_q      <= al_b_d;
      dl_a_q      <= dl_a_d;
      dl_b_q      <= dl_b_d;
      p_q         <= p_d;
      vld_q       <= vld_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_out_q   <= max_out_d;
      max_idx_q   <= max_idx_d;
      max_valid_q <= max_valid_d;
      over_thr_q  <= over_thr_d;
    end
  end

  assign SUM_OUT   = sum_q;
  assign SUM_VALID = sum_valid;
  assign OVER_THR  = over_thr_q;
  assign MAX_OUT   = max_out_q;
  assign MAX_IDX   = max_idx_q;
  assign MAX_VALID = max_valid_q;

endmodule

// File: tb/tb_quad_corr_cascade_sum.sv
// tb/tb_quad_corr_cascade_sum.sv - scoreboard bench for quad_corr_cascade_sum
module tb_quad_corr_cascade_sum;

  localparam int WINDOW = 8;

  logic        clk;
  logic        rst;
  logic [11:0] STAGE1A, STAGE1B, STAGE2A, STAGE2B, STAGE3A, STAGE3B;
  logic [11:0] STAGE4A, STAGE4B, STAGE5A, STAGE5B, STAGE6A, STAGE6B;
  logic [11:0] THRESHOLD;
  logic [11:0] SUM_OUT;
  logic        SUM_VALID;
  logic        OVER_THR;
  logic [11:0] MAX_OUT;
  logic [7:0]  MAX_IDX;
  logic        MAX_VALID;

  quad_corr_cascade_sum #(
    .DSPBITS(12), .SUMBITS(12), .WINDOW(WINDOW), .IDXBITS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .STAGE1A(STAGE1A), .STAGE1B(STAGE1B), .STAGE2A(STAGE2A), .STAGE2B(STAGE2B),
    .STAGE3A(STAGE3A), .STAGE3B(STAGE3B), .STAGE4A(STAGE4A), .STAGE4B(STAGE4B),
    .STAGE5A(STAGE5A), .STAGE5B(STAGE5B), .STAGE6A(STAGE6A), .STAGE6B(STAGE6B),
    .THRESHOLD(THRESHOLD),
    .SUM_OUT(SUM_OUT), .SUM_VALID(SUM_VALID), .OVER_THR(OVER_THR),
    .MAX_OUT(MAX_OUT), .MAX_IDX(MAX_IDX), .MAX_VALID(MAX_VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [11:0] nxt [12];
  logic [11:0] prv [12];
  logic        nxt_rst;
  logic [11:0] nxt_thr;
  int          n;
  logic        cur_valid;
  logic [11:0] cur_sum;
  logic        exp_over;
  logic [11:0] exp_max;
  logic [7:0]  exp_idx;
  logic [11:0] sb_q [$];
  logic [11:0] win_q [$];
  int          tbl [11] = '{5, 9, 3, 9, 1, 0, 2, 4, 99, 100, 101};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_set();
    for (int i = 0; i < 12; i++) nxt[i] = '0;
  endtask

  // Drive one set (stages 5-6 lag by a clock), advance one edge, then score.
  task automatic tick();
    logic [11:0] s;
    logic        exp_mv;
    rst = nxt_rst;
    STAGE1A = nxt[0]; STAGE1B = nxt[1]; STAGE2A = nxt[2]; STAGE2B = nxt[3];
    STAGE3A = nxt[4]; STAGE3B = nxt[5]; STAGE4A = nxt[6]; STAGE4B = nxt[7];
    STAGE5A = prv[8]; STAGE5B = prv[9]; STAGE6A = prv[10]; STAGE6B = prv[11];
    THRESHOLD = nxt_thr;
    s = '0;
    for (int i = 0; i < 12; i++) s = s + nxt[i];
    if (!nxt_rst) sb_q.push_back(s);
    exp_over = !nxt_rst && cur_valid && (cur_sum >= nxt_thr);
    prv = nxt;
    @(posedge clk);
    #1;
    if (nxt_rst) begin
      n = 0;
      sb_q.delete();
      win_q.delete();
      cur_valid = 1'b0;
      cur_sum   = '0;
      exp_max   = '0;
      exp_idx   = '0;
      chk("rst_sum_out", SUM_OUT, 0);
      chk("rst_sum_valid", SUM_VALID, 0);
      chk("rst_over_thr", OVER_THR, 0);
      chk("rst_max_valid", MAX_VALID, 0);
    end else begin
      n++;
      chk("over_thr", OVER_THR, exp_over);
      exp_mv = (win_q.size() == WINDOW);
      if (exp_mv) begin
        exp_max = win_q[0];
        exp_idx = 8'd0;
        for (int i = 1; i < WINDOW; i++) begin
          if (win_q[i] > exp_max) begin
            exp_max = win_q[i];
            exp_idx = 8'(i);
          end
        end
        win_q.delete();
      end
      chk("max_valid", MAX_VALID, exp_mv);
      cur_valid = (n >= 7);
      chk("sum_valid", SUM_VALID, cur_valid);
      if (cur_valid && sb_q.size() > 0) begin
        cur_sum = sb_q.pop_front();
        chk("sum_out", SUM_OUT, cur_sum);
        win_q.push_back(cur_sum);
      end
    end
    chk("max_out", MAX_OUT, exp_max);
    chk("max_idx", MAX_IDX, exp_idx);
  endtask

  initial begin
    rst = 1'b1;
    {STAGE1A, STAGE1B, STAGE2A, STAGE2B, STAGE3A, STAGE3B} = '0;
    {STAGE4A, STAGE4B, STAGE5A, STAGE5B, STAGE6A, STAGE6B} = '0;
    THRESHOLD = '0;
    for (int i = 0; i < 12; i++) begin
      nxt[i] = '0;
      prv[i] = '0;
    end
    n = 0; cur_valid = 0; cur_sum = '0; exp_over = 0; exp_max = '0; exp_idx = '0;
    nxt_thr = '0;

    // Reset, then all-zero inputs with THRESHOLD=0.
    nxt_rst = 1'b1;
    tick();
    tick();
    nxt_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (n == 6) chk("zero_no_valid_at_6", SUM_VALID, 0);
      if (n == 7) chk("zero_over_not_yet_7", OVER_THR, 0);
      if (n == 8) chk("zero_over_from_8", OVER_THR, 1);
      if (n == 14) chk("zero_no_peak_at_14", MAX_VALID, 0);
      if (n == 15) begin
        chk("zero_peak_strobe", MAX_VALID, 1);
        chk("zero_peak_val", MAX_OUT, 0);
        chk("zero_peak_idx", MAX_IDX, 0);
      end
    end

    // Full scale held constant.
    for (int i = 0; i < 12; i++) nxt[i] = (i < 8) ? 12'd63 : 12'd126;
    for (int i = 0; i < 24; i++) tick();
    chk("full_sum", SUM_OUT, 1008);
    chk("full_peak_val", MAX_OUT, 1008);
    chk("full_peak_idx", MAX_IDX, 0);

    // Tie window, threshold edge and latency probe from a fresh reset.
    clear_set();
    nxt_thr = 12'd100;
    nxt_rst = 1'b1;
    tick();
    nxt_rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      clear_set();
      if (i < 11) nxt[5] = 12'(tbl[i]);
      if (i == 12) begin
        nxt[0]  = 12'd1;
        nxt[11] = 12'd2;
      end
      tick();
      if (n == 15) begin
        chk("tie_peak_strobe", MAX_VALID, 1);
        chk("tie_peak_val", MAX_OUT, 9);
        chk("tie_peak_idx", MAX_IDX, 1);
      end
      if (n == 16) begin
        chk("tie_strobe_single", MAX_VALID, 0);
        chk("thr_99", OVER_THR, 0);
      end
      if (n == 17) chk("thr_100", OVER_THR, 1);
      if (n == 18) begin
        chk("thr_101", OVER_THR, 1);
        chk("probe_before", SUM_OUT, 0);
      end
      if (n == 19) chk("probe_hit", SUM_OUT, 3);
      if (n == 20) chk("probe_after", SUM_OUT, 0);
    end

    // Random full-range values exercise modulo wrap and random thresholds.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 12; k++) nxt[k] = 12'($urandom_range(0, 4095));
      nxt_thr = 12'($urandom_range(0, 4095));
      tick();
    end

    // Reset mid-window at cnt=4, then a full restart.
    nxt_rst = 1'b1;
    tick();
    nxt_rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 12; k++) nxt[k] = 12'($urandom_range(0, 126));
      nxt_thr = 12'($urandom_range(0, 1008));
      tick();
    end
    nxt_rst = 1'b1;
    tick();
    nxt_rst = 1'b0;
    for (int i = 0; i < 26; i++) begin
      for (int k = 0; k < 12; k++) nxt[k] = 12'($urandom_range(0, 126));
      nxt_thr = 12'($urandom_range(0, 1008));
      tick();
      if (n == 6) chk("rerst_fill_low", SUM_VALID, 0);
      if (n == 14) chk("rerst_no_early_peak", MAX_VALID, 0);
      if (n == 15) chk("rerst_peak_at_15", MAX_VALID, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
